// File: rtl/freq_meas_sched_if.sv
// Engine-side and result-side signals of the frequency-measurement scheduler.
// master: the scheduler (drives mux select, start/abort and the tagged result).
// slave : the engine plus result consumer (drives done strobe and measured value).
interface freq_meas_sched_if #(
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 9
);
    // engine control / status
    logic [SEL_WIDTH-1:0]  meas_sel_o;
    logic                  meas_start_o;
    logic                  meas_abort_o;
    logic                  meas_done_i;
    logic [DATA_WIDTH-1:0] meas_val_i;

    // tagged result
    logic                  res_valid_o;
    logic [SEL_WIDTH-1:0]  res_ch_o;
    logic [DATA_WIDTH-1:0] res_data_o;
    logic                  res_err_o;

    modport master (
        output meas_sel_o,
        output meas_start_o,
        output meas_abort_o,
        input  meas_done_i,
        input  meas_val_i,
        output res_valid_o,
        output res_ch_o,
        output res_data_o,
        output res_err_o
    );

    modport slave (
        input  meas_sel_o,
        input  meas_start_o,
        input  meas_abort_o,
        output meas_done_i,
        output meas_val_i,
        input  res_valid_o,
        input  res_ch_o,
        input  res_data_o,
        input  res_err_o
    );
endinterface

// File: rtl/freq_meas_sched.sv
// Round-robin scheduler sharing one frequency-measurement engine among CH_CNT channels.
// Latency: request pulse to engine start >= 2 clk_i cycles; grant-to-grant spacing >= 4 cycles.
// Backpressure: requests merge into one pending bit per channel; en_i low only holds off new grants.
//
// Ports: clk_i / rst_n_i (async active-low), en_i, req_i[CH_CNT], pend_o[CH_CNT], busy_o,
//        eng (freq_meas_sched_if.master): engine select/start/abort/done/value and the
//        channel-tagged result (valid strobe, channel, data, timeout error).
module freq_meas_sched #(
    parameter int CH_CNT         = 4,
    parameter int DATA_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [CH_CNT-1:0] req_i,
    output logic [CH_CNT-1:0] pend_o,
    output logic              busy_o,
    freq_meas_sched_if.master eng
);

    localparam int SEL_WIDTH = $clog2(CH_CNT);
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_CNT-1:0] ONE_HOT0 = CH_CNT'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CH_CNT-1:0]     pend_q, pend_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  abort_q, abort_d;

    // round-robin pick
    logic [SEL_WIDTH-1:0]  grant;
    logic [SEL_WIDTH-1:0]  cand;
    logic                  grant_vld;
    int                    rr_idx;

    // Scan pointer+CH_CNT down to pointer+1 so the last hit written is the
    // first pending channel above the pointer (wrapping through CH_CNT).
    always_comb begin : rr_pick
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        rr_idx    = 0;
        for (int i = CH_CNT; i >= 1; i--) begin
            rr_idx = (int'(ptr_q) + i) % CH_CNT;
            cand   = SEL_WIDTH'(rr_idx);
            if (pend_q[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    // next-state and datapath updates
    always_comb begin : fsm_next
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        abort_d = 1'b0;
        // new requests always set their bit, including during DONE
        pend_d  = pend_q | req_i;

        case (state_q)
            IDLE: begin
                if (en_i && grant_vld) begin
                    sel_d   = grant;
                    state_d = START;
                end
            end

            START: begin
                // done strobes here are deliberately not looked at
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // done has priority over a timeout landing on the same cycle
                if (eng.meas_done_i) begin
                    data_d  = eng.meas_val_i;
                    err_d   = 1'b0;
                    ch_d    = sel_q;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    ch_d    = sel_q;
                    state_d = DONE;
                end
            end

            DONE: begin
                ptr_d   = sel_q;
                // a request arriving in this very cycle keeps the bit set
                pend_d  = (pend_q & ~(ONE_HOT0 << sel_q)) | req_i;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin : fsm_reg
        if (!rst_n_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            // pointer parked on the last channel so channel 0 wins first
            ptr_q   <= SEL_WIDTH'(CH_CNT - 1);
            ch_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    // Abort is registered on the WAIT->DONE transition, so it coincides with
    // the error result strobe in the DONE cycle.
    assign pend_o           = pend_q;
    assign busy_o           = (state_q != IDLE);
    assign eng.meas_sel_o   = sel_q;
    assign eng.meas_start_o = (state_q == START);
    assign eng.meas_abort_o = abort_q;
    assign eng.res_valid_o  = (state_q == DONE);
    assign eng.res_ch_o     = ch_q;
    assign eng.res_data_o   = data_q;
    assign eng.res_err_o    = err_q;

    // structural invariants
    a_start_pulse: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        eng.meas_start_o |=> !eng.meas_start_o);
    a_abort_err: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        eng.meas_abort_o |-> (eng.res_valid_o && eng.res_err_o));
    a_valid_pulse: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        eng.res_valid_o |=> !eng.res_valid_o);

endmodule

// File: tb/tb_freq_meas_sched.sv
module tb_freq_meas_sched;

    localparam int CH_CNT         = 4;
    localparam int DATA_WIDTH     = 9;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int SEL_WIDTH      = 2;
    localparam int NV             = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [3:0]  req   = 4'b0000;
    logic [3:0]  pend;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    freq_meas_sched_if #(.SEL_WIDTH(SEL_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    freq_meas_sched #(
        .CH_CNT        (CH_CNT),
        .DATA_WIDTH    (DATA_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .en_i   (en),
        .req_i  (req),
        .pend_o (pend),
        .busy_o (busy),
        .eng    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       done;
        logic [8:0] val;
        logic       x_start;
        logic       x_busy;
        logic [1:0] x_sel;
        logic [3:0] x_pend;
        logic       x_valid;
        logic [1:0] x_ch;
        logic [8:0] x_data;
        logic       x_err;
        logic       x_abort;
    } vec_t;

    vec_t vecs [NV];

    task automatic setv(input int i, input logic e, input logic [3:0] r, input logic d,
                        input logic [8:0] v, input logic xs, input logic xb,
                        input logic [1:0] xsel, input logic [3:0] xp, input logic xv,
                        input logic [1:0] xc, input logic [8:0] xd, input logic xe,
                        input logic xa);
        vecs[i].en = e;       vecs[i].req = r;       vecs[i].done = d;   vecs[i].val = v;
        vecs[i].x_start = xs; vecs[i].x_busy = xb;   vecs[i].x_sel = xsel;
        vecs[i].x_pend = xp;  vecs[i].x_valid = xv;  vecs[i].x_ch = xc;
        vecs[i].x_data = xd;  vecs[i].x_err = xe;    vecs[i].x_abort = xa;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_start(input logic [1:0] ch, input string nm);
        int n;
        n = 0;
        while (bus.meas_start_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({nm, ".start"}, 32'(bus.meas_start_o), 32'(1));
        chk({nm, ".sel"},   32'(bus.meas_sel_o),   32'(ch));
    endtask

    // grant expected on ch; engine answers dly cycles after the START cycle
    task automatic serve(input logic [1:0] ch, input int dly, input logic [8:0] val,
                         input string nm);
        wait_start(ch, nm);
        repeat (dly) tick();
        bus.meas_done_i = 1'b1;
        bus.meas_val_i  = val;
        tick();
        bus.meas_done_i = 1'b0;
        bus.meas_val_i  = '0;
        chk({nm, ".valid"}, 32'(bus.res_valid_o),  32'(1));
        chk({nm, ".ch"},    32'(bus.res_ch_o),     32'(ch));
        chk({nm, ".data"},  32'(bus.res_data_o),   32'(val));
        chk({nm, ".err"},   32'(bus.res_err_o),    32'(0));
        chk({nm, ".abort"}, 32'(bus.meas_abort_o), 32'(0));
        chk({nm, ".dsel"},  32'(bus.meas_sel_o),   32'(ch));
        tick();
        chk({nm, ".valid_off"}, 32'(bus.res_valid_o), 32'(0));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".pend"},  32'(pend),             32'(0));
        chk({nm, ".busy"},  32'(busy),             32'(0));
        chk({nm, ".start"}, 32'(bus.meas_start_o), 32'(0));
        chk({nm, ".abort"}, 32'(bus.meas_abort_o), 32'(0));
        chk({nm, ".sel"},   32'(bus.meas_sel_o),   32'(0));
        chk({nm, ".valid"}, 32'(bus.res_valid_o),  32'(0));
        chk({nm, ".ch"},    32'(bus.res_ch_o),     32'(0));
        chk({nm, ".data"},  32'(bus.res_data_o),   32'(0));
        chk({nm, ".err"},   32'(bus.res_err_o),    32'(0));
    endtask

    initial begin
        int n;
        logic [3:0] xp;

        //          en    req      done  val      start busy  sel    pend     valid ch     data     err   abort
        setv(0, 1'b0, 4'b0010, 1'b0, 9'd0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 9'd0,  1'b0, 1'b0);
        setv(1, 1'b0, 4'b0000, 1'b0, 9'd0,  1'b0, 1'b0, 2'd0, 4'b0010, 1'b0, 2'd0, 9'd0,  1'b0, 1'b0);
        setv(2, 1'b0, 4'b0000, 1'b0, 9'd0,  1'b0, 1'b0, 2'd0, 4'b0010, 1'b0, 2'd0, 9'd0,  1'b0, 1'b0);
        setv(3, 1'b1, 4'b0000, 1'b0, 9'd0,  1'b0, 1'b0, 2'd0, 4'b0010, 1'b0, 2'd0, 9'd0,  1'b0, 1'b0);
        setv(4, 1'b1, 4'b0000, 1'b1, 9'd5,  1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 2'd0, 9'd0,  1'b0, 1'b0);
        setv(5, 1'b1, 4'b0000, 1'b0, 9'd0,  1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 2'd0, 9'd0,  1'b0, 1'b0);
        setv(6, 1'b0, 4'b0000, 1'b1, 9'd77, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 2'd0, 9'd0,  1'b0, 1'b0);
        setv(7, 1'b0, 4'b0000, 1'b0, 9'd0,  1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1, 9'd77, 1'b0, 1'b0);
        setv(8, 1'b1, 4'b0000, 1'b0, 9'd0,  1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 2'd1, 9'd77, 1'b0, 1'b0);
        setv(9, 1'b1, 4'b0000, 1'b0, 9'd0,  1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 2'd1, 9'd77, 1'b0, 1'b0);

        bus.meas_done_i = 1'b0;
        bus.meas_val_i  = '0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // enable gating, done-in-START ignored, en drop mid-measurement, hold after DONE
        for (int i = 0; i < NV; i++) begin
            en              = vecs[i].en;
            req             = vecs[i].req;
            bus.meas_done_i = vecs[i].done;
            bus.meas_val_i  = vecs[i].val;
            chk($sformatf("v%0d.start", i), 32'(bus.meas_start_o), 32'(vecs[i].x_start));
            chk($sformatf("v%0d.busy", i),  32'(busy),             32'(vecs[i].x_busy));
            chk($sformatf("v%0d.sel", i),   32'(bus.meas_sel_o),   32'(vecs[i].x_sel));
            chk($sformatf("v%0d.pend", i),  32'(pend),             32'(vecs[i].x_pend));
            chk($sformatf("v%0d.valid", i), 32'(bus.res_valid_o),  32'(vecs[i].x_valid));
            chk($sformatf("v%0d.ch", i),    32'(bus.res_ch_o),     32'(vecs[i].x_ch));
            chk($sformatf("v%0d.data", i),  32'(bus.res_data_o),   32'(vecs[i].x_data));
            chk($sformatf("v%0d.err", i),   32'(bus.res_err_o),    32'(vecs[i].x_err));
            chk($sformatf("v%0d.abort", i), 32'(bus.meas_abort_o), 32'(vecs[i].x_abort));
            tick();
        end
        req             = 4'b0000;
        bus.meas_done_i = 1'b0;
        bus.meas_val_i  = '0;
        en              = 1'b1;

        // asynchronous reset in the middle of WAIT
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        tick();
        tick();
        chk("arst.pre_busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // request at cycle n -> start at n+2
        req = 4'b0100;
        chk("lat.n0", 32'(bus.meas_start_o), 32'(0));
        tick();
        req = 4'b0000;
        chk("lat.n1", 32'(bus.meas_start_o), 32'(0));
        tick();
        chk("lat.n2", 32'(bus.meas_start_o), 32'(1));
        chk("lat.sel", 32'(bus.meas_sel_o), 32'(2));
        tick();
        bus.meas_done_i = 1'b1;
        bus.meas_val_i  = 9'd33;
        tick();
        bus.meas_done_i = 1'b0;
        bus.meas_val_i  = '0;
        chk("lat.valid", 32'(bus.res_valid_o), 32'(1));
        chk("lat.data",  32'(bus.res_data_o),  32'(33));
        chk("lat.ch",    32'(bus.res_ch_o),    32'(2));
        tick();

        // single request, answer 10 cycles after start
        req = 4'b0010;
        tick();
        req = 4'b0000;
        serve(2'd1, 10, 9'd137, "single");
        chk("single.pend", 32'(pend), 32'(0));

        // round robin from reset: 0,1,2,3 then 0,1
        rst_pulse();
        req = 4'b1111;
        tick();
        req = 4'b0000;
        chk("rr.pend", 32'(pend), 32'(4'b1111));
        for (int k = 0; k < 4; k++) begin
            serve(2'(k), 3, 9'(10 + k), $sformatf("rr%0d", k));
            xp = (4'b1111 << (k + 1));
            chk($sformatf("rr%0d.pend", k), 32'(pend), 32'(xp));
        end
        req = 4'b0011;
        tick();
        req = 4'b0000;
        serve(2'd0, 3, 9'd20, "rrb0");
        serve(2'd1, 3, 9'd21, "rrb1");

        // timeout on channel 3
        req = 4'b1000;
        tick();
        req = 4'b0000;
        wait_start(2'd3, "tmo");
        tick();
        n = 0;
        while (bus.meas_abort_o !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        chk("tmo.len",   32'(n), 32'(TIMEOUT_CYCLES));
        chk("tmo.valid", 32'(bus.res_valid_o), 32'(1));
        chk("tmo.err",   32'(bus.res_err_o),   32'(1));
        chk("tmo.data",  32'(bus.res_data_o),  32'(0));
        chk("tmo.ch",    32'(bus.res_ch_o),    32'(3));
        tick();
        chk("tmo.abort_off", 32'(bus.meas_abort_o), 32'(0));
        chk("tmo.err_hold",  32'(bus.res_err_o),    32'(1));

        // done on the last counter value wins over timeout
        req = 4'b0100;
        tick();
        req = 4'b0000;
        serve(2'd2, TIMEOUT_CYCLES, 9'd200, "edge");

        // request on the channel being completed keeps it pending
        req = 4'b0001;
        tick();
        req = 4'b0000;
        wait_start(2'd0, "redo");
        tick();
        tick();
        bus.meas_done_i = 1'b1;
        bus.meas_val_i  = 9'd50;
        tick();
        bus.meas_done_i = 1'b0;
        bus.meas_val_i  = '0;
        chk("redo.valid", 32'(bus.res_valid_o), 32'(1));
        req = 4'b0001;
        tick();
        req = 4'b0000;
        chk("redo.pend", 32'(pend), 32'(4'b0001));
        serve(2'd0, 2, 9'd51, "redo2");
        chk("redo2.pend", 32'(pend), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
